// File: rtl/mux_rr_arbiter_pkg.sv
// Shared encodings and sizes for the 4-source round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_arbiter_pick4.sv
// Wrap-around priority picker: first set request bit searching upward
// from (ptr+1) mod 4.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan offsets 1..4 from the pointer; the first hit wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux. One grant at
// a time, held until done, requester withdrawal, or MAX_HOLD cycles.
//
//   state | meaning
//   IDLE  | no grant; arbitrate among pending requests
//   GRANT | one source owns the mux; count hold cycles
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              done,
  output logic [NREQ-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  output logic              valid,
  output logic              timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [SEL_W-1:0]  ptr, ptr_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic              valid_nxt;
  logic              timeout_nxt;
  logic [SEL_W-1:0]  win;
  logic              any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-output decode; everything lands in registers.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    gnt_nxt     = gnt;
    valid_nxt   = valid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        if (any) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << win;
          sel_nxt   = win;
          valid_nxt = 1'b1;
          hold_nxt  = HOLD_W'(1);
          ptr_nxt   = win;
        end
      end
      GRANT: begin
        if (done || !req[sel] || (hold == HOLD_LIMIT)) begin
          // done wins over a coincident hold limit, so no timeout then.
          timeout_nxt = !done && req[sel];
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          valid_nxt   = 1'b0;
          hold_nxt    = '0;
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
      end
    endcase
  end

  // Output, pointer and hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      hold    <= '0;
      ptr     <= SEL_W'(3);
    end else begin
      gnt     <= gnt_nxt;
      sel     <= sel_nxt;
      valid   <= valid_nxt;
      timeout <= timeout_nxt;
      hold    <= hold_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for the round-robin mux arbiter.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the structural invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_valid", 32'(valid), 32'(gnt != 4'b0000));
    chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (valid) chk("inv_sel", 32'(gnt), 32'(4'b0001 << sel));
  endtask

  task automatic expect_grant(input string tag, input int src);
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << src));
    chk({tag, "_sel"}, 32'(sel), 32'(src));
    chk({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  task automatic expect_idle(input string tag, input int src, input logic to);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'(src));
    chk({tag, "_timeout"}, 32'(timeout), 32'(to));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #1;
    expect_idle("reset", 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single request, done release
    req = 4'b0100;
    tick();
    expect_grant("t1_grant", 2);
    done = 1'b1;
    tick();
    expect_idle("t1_release", 2, 1'b0);
    done = 1'b0;
    req  = 4'b0000;

    // 2: rotation from reset pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      expect_grant("t2_first", order[g]);
      tick();
      expect_grant("t2_second", order[g]);
      done = 1'b1;
      tick();
      expect_idle("t2_gap", order[g], 1'b0);
      done = 1'b0;
      if (g == 4) req = 4'b0000;
      tick();
    end
    expect_idle("t2_end", 0, 1'b0);

    // 3: timeout after 8 held cycles, then re-grant
    req = 4'b0001;
    tick();
    expect_grant("t3_h1", 0);
    for (int h = 2; h <= 8; h++) begin
      tick();
      expect_grant("t3_hold", 0);
      chk("t3_hold_to", 32'(timeout), 32'd0);
    end
    tick();
    expect_idle("t3_timeout", 0, 1'b1);
    tick();
    expect_grant("t3_regrant", 0);
    chk("t3_regrant_to", 32'(timeout), 32'd0);
    req = 4'b0000;
    tick();
    expect_idle("t3_withdraw", 0, 1'b0);

    // 4: withdrawal, pending source 3 follows
    req = 4'b0100;
    tick();
    expect_grant("t4_grant2", 2);
    req = 4'b1000;
    tick();
    expect_idle("t4_withdraw", 2, 1'b0);
    tick();
    expect_grant("t4_grant3", 3);
    req = 4'b0000;
    tick();
    expect_idle("t4_end", 3, 1'b0);

    // 5: done coincident with hold limit
    req = 4'b0001;
    tick();
    expect_grant("t5_grant", 0);
    repeat (7) tick();
    expect_grant("t5_h8", 0);
    done = 1'b1;
    tick();
    expect_idle("t5_release", 0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    expect_idle("t5_end", 0, 1'b0);

    // 6: async reset mid-grant
    req = 4'b0010;
    tick();
    expect_grant("t6_grant", 1);
    #2 rst = 1'b1;
    #1;
    expect_idle("t6_async", 0, 1'b0);
    req = 4'b0011;
    #1 rst = 1'b0;
    tick();
    expect_grant("t6_after", 0);
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
